lsu_mem_ctrl: RTL

- Load/store initiator between the CPU datapath and the word-wide data memory.
- Accepts one RISC-V load/store request at a time, aligns the byte address, and issues word reads/writes with a fixed read latency.
- Performs read-modify-write for SB/SH, and sign/zero-extends LB/LH/LBU/LHU results.
- Returns a single-cycle response carrying data or an error flag for misaligned or illegal accesses.

---
 rtl/lsu_mem_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding RISC-V load/store unit in front of a word-wide data memory.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid/req_ready      request handshake; ready only while idle
//   req_we, req_funct3       store flag and RISC-V access width/sign code
//   req_addr, req_wdata      byte address and store data
//   resp_valid/rdata/err     one-cycle completion with extended load data or error flag
//   mem_addr/we/wd, mem_rd   word-aligned memory port with fixed read latency
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE, RESP} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, rdata_q, rdata_d, wd_q, wd_d, load_val, merged;
    logic [15:0]           wdata_q, wdata_d, half_sel;
    logic [7:0]            byte_sel;
    logic [2:0]            f3_q, f3_d, cnt_q, cnt_d;
    logic                  we_q, we_d, err_q, err_d, illegal, misal;
    assign illegal = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'b011 || req_funct3 > 3'b101);
    assign misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign byte_sel = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_rd[{addr_q[1], 4'b0000} +: 16];
    assign load_val = f3_q == 3'b000 ? {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel} :
                      f3_q == 3'b001 ? {{(DATA_WIDTH-16){half_sel[15]}}, half_sel} :
                      f3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_sel} :
                      f3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_sel} : mem_rd;
    // Sub-word store: splice the new byte/half into the word just read back.
    always_comb begin
        merged = mem_rd;
        if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                f3_d    = req_funct3;
                we_d    = req_we;
                wdata_d = req_wdata[15:0];
                wd_d    = req_wdata;
                cnt_d   = 3'(MEM_LATENCY);
                rdata_d = '0;
                err_d   = illegal || misal;
                state_d = (illegal || misal) ? RESP :
                          (req_we && req_funct3 == 3'b010) ? WRITE : READ_WAIT;
            end
            // Counter reaching zero marks the cycle mem_rd is valid for mem_addr.
            READ_WAIT: if (cnt_q == 3'd0) begin
                state_d = we_q ? WRITE : RESP;
                rdata_d = we_q ? '0 : load_val;
                wd_d    = we_q ? merged : wd_q;
            end else cnt_d = cnt_q - 3'd1;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;
    assign mem_we     = state_q == WRITE;
    assign mem_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_wd     = wd_q;
endmodule
